// File: rtl/t_core_ff_converter.sv
// Multi-lane universal flip-flop built on T-FF cores: D/JK/SR/T semantics are converted to a T excitation per lane,
// with an SR-illegal monitor (sticky flag + saturating count) and a saturating toggle-activity counter.
module t_core_ff_converter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_exc,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;

  logic             sr_event;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] tsum;

  // S=R=1 yields t=0 so an SR lane simply holds.
  always_comb begin
    t_exc = '0;
    if (en) begin
      case (mode)
        MODE_D:  t_exc = a ^ q;
        MODE_JK: t_exc = (a & ~q) | (b & q);
        MODE_SR: t_exc = (a & ~q & ~b) | (b & q & ~a);
        default: t_exc = a;
      endcase
    end
  end

  assign sr_event = en && (mode == MODE_SR) && (|(a & b));

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SUM_W'(t_exc[i]);
    end
  end

  assign tsum = SUM_W'(toggle_cnt) + pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q ^ t_exc;
    end
  end

  // An event in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (sr_event) begin
      illegal <= 1'b1;
      if (clr_err) begin
        illegal_cnt <= CNT_W'(1);
      end else if (illegal_cnt != {CNT_W{1'b1}}) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end else if (clr_err) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if (tsum > CNT_MAX) begin
      toggle_cnt <= {CNT_W{1'b1}};
    end else begin
      toggle_cnt <= tsum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_t_core_ff_converter.sv
// Self-checking bench for t_core_ff_converter: directed vector table, hand sequences and a random scoreboard phase.
module tb_t_core_ff_converter;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          clr_err;
  logic [W-1:0]  q;
  logic [W-1:0]  t_exc;
  logic          illegal;
  logic [CW-1:0] illegal_cnt;
  logic [CW-1:0] toggle_cnt;

  t_core_ff_converter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q), .t_exc(t_exc), .illegal(illegal), .illegal_cnt(illegal_cnt), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  q;
    logic          ill;
    logic [CW-1:0] icnt;
    logic [CW-1:0] tcnt;
  } st_t;

  typedef struct packed {
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] exp_t;
    st_t          exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  st_t  sbq[$];
  st_t  m;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: t_exc checked before the edge, registered state checked after.
  task automatic drive(input logic en_i, input logic [1:0] mode_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input logic clr_i,
                       input logic [W-1:0] exp_t, input st_t exp);
    st_t e;
    @(negedge clk);
    en = en_i; mode = mode_i; a = a_i; b = b_i; clr_err = clr_i;
    #1;
    chk("t_exc", int'(t_exc), int'(exp_t));
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("q", int'(q), int'(e.q));
    chk("illegal", int'(illegal), int'(e.ill));
    chk("illegal_cnt", int'(illegal_cnt), int'(e.icnt));
    chk("toggle_cnt", int'(toggle_cnt), int'(e.tcnt));
  endtask

  // Reference model from the flip-flop truth tables.
  task automatic mstep(input logic en_i, input logic [1:0] mode_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input logic clr_i);
    logic [W-1:0] nq;
    logic [W-1:0] tt;
    logic         ev;
    int           sum;
    nq = m.q;
    for (int i = 0; i < W; i++) begin
      if (en_i) begin
        case (mode_i)
          2'b00: nq[i] = a_i[i];
          2'b01: case ({a_i[i], b_i[i]})
                   2'b01: nq[i] = 1'b0;
                   2'b10: nq[i] = 1'b1;
                   2'b11: nq[i] = ~m.q[i];
                   default: nq[i] = m.q[i];
                 endcase
          2'b10: case ({a_i[i], b_i[i]})
                   2'b01: nq[i] = 1'b0;
                   2'b10: nq[i] = 1'b1;
                   default: nq[i] = m.q[i];
                 endcase
          default: nq[i] = m.q[i] ^ a_i[i];
        endcase
      end
    end
    tt  = nq ^ m.q;
    ev  = en_i && (mode_i == 2'b10) && ((a_i & b_i) != '0);
    sum = int'(m.tcnt) + $countones(tt);
    m.tcnt = (sum > 15) ? 4'hF : CW'(sum);
    if (ev) begin
      m.ill  = 1'b1;
      m.icnt = clr_i ? CW'(1) : ((m.icnt == 4'hF) ? 4'hF : m.icnt + 1'b1);
    end else if (clr_i) begin
      m.ill  = 1'b0;
      m.icnt = '0;
    end
    m.q = nq;
    drive(en_i, mode_i, a_i, b_i, clr_i, tt, m);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_illegal_cnt", int'(illegal_cnt), 0);
    chk("rst_toggle_cnt", int'(toggle_cnt), 0);
    en = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m = '0;
  endtask

  vec_t tbl[17];
  logic [3:0] sat_t [5] = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 4'hA, 4'h0, 1'b0, 4'hA, '{4'hA, 1'b0, 4'd0, 4'd2}};
    tbl[1]  = '{1'b1, 2'b00, 4'h5, 4'h0, 1'b0, 4'hF, '{4'h5, 1'b0, 4'd0, 4'd6}};
    tbl[2]  = '{1'b1, 2'b01, 4'hC, 4'hA, 1'b0, 4'h8, '{4'hD, 1'b0, 4'd0, 4'd7}};
    tbl[3]  = '{1'b1, 2'b00, 4'h7, 4'h0, 1'b0, 4'hA, '{4'h7, 1'b0, 4'd0, 4'd9}};
    tbl[4]  = '{1'b1, 2'b10, 4'h5, 4'h6, 1'b0, 4'h2, '{4'h5, 1'b1, 4'd1, 4'd10}};
    tbl[5]  = '{1'b1, 2'b10, 4'h5, 4'h6, 1'b0, 4'h0, '{4'h5, 1'b1, 4'd2, 4'd10}};
    tbl[6]  = '{1'b1, 2'b10, 4'h5, 4'h6, 1'b0, 4'h0, '{4'h5, 1'b1, 4'd3, 4'd10}};
    tbl[7]  = '{1'b1, 2'b00, 4'h5, 4'h0, 1'b1, 4'h0, '{4'h5, 1'b0, 4'd0, 4'd10}};
    tbl[8]  = '{1'b1, 2'b10, 4'h5, 4'h6, 1'b1, 4'h0, '{4'h5, 1'b1, 4'd1, 4'd10}};
    tbl[9]  = '{1'b1, 2'b00, 4'h5, 4'h0, 1'b1, 4'h0, '{4'h5, 1'b0, 4'd0, 4'd10}};
    for (int i = 10; i < 14; i++)
      tbl[i] = '{1'b0, 2'b10, 4'hF, 4'hF, 1'b0, 4'h0, '{4'h5, 1'b0, 4'd0, 4'd10}};
    tbl[14] = '{1'b1, 2'b11, 4'h1, 4'h0, 1'b0, 4'h1, '{4'h4, 1'b0, 4'd0, 4'd11}};
    tbl[15] = '{1'b1, 2'b01, 4'hF, 4'hF, 1'b0, 4'hF, '{4'hB, 1'b0, 4'd0, 4'd15}};
    tbl[16] = '{1'b1, 2'b01, 4'hF, 4'hF, 1'b0, 4'hF, '{4'h4, 1'b0, 4'd0, 4'd15}};

    rst = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_err = 1'b0;
    m = '0;
    #12;
    rst = 1'b0;

    // Load q=F and set the illegal flag so the mid-cycle reset has something to clear.
    mstep(1'b1, 2'b11, 4'hF, 4'h0, 1'b0);
    mstep(1'b1, 2'b10, 4'h1, 4'h1, 1'b0);
    mid_reset();

    foreach (tbl[i])
      drive(tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].exp_t, tbl[i].exp);

    // Toggle counter saturation from reset: q alternates F/0, count clamps at 15.
    mid_reset();
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2'b11, 4'hF, 4'h0, 1'b0, 4'hF,
            '{(i % 2 == 0) ? 4'hF : 4'h0, 1'b0, 4'd0, sat_t[i]});
    m = '{4'hF, 1'b0, 4'd0, 4'd15};

    // Illegal counter saturation.
    mid_reset();
    for (int i = 0; i < 17; i++)
      mstep(1'b1, 2'b10, 4'h3, 4'h1, 1'b0);
    chk("icnt_saturated", int'(illegal_cnt), 15);

    // Random mixed traffic against the model, with occasional resets.
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) mid_reset();
      mstep(($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
